// File: rtl/ex_stage_if.sv
// Decode-to-execute and execute-to-memory bundle of the ex_stage.
// The master side drives instructions in; the slave side is the execute stage.
interface ex_stage_if;
  logic        in_valid;
  logic [4:0]  instr_bits_15_11;
  logic [4:0]  instr_bits_20_16;
  logic [31:0] extended_bits;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [31:0] new_pc_value;
  logic        RegDst;
  logic        RegWrite;
  logic        ALUSrc;
  logic        MemWrite;
  logic        MemRead;
  logic        MemToReg;
  logic        Branch;
  logic [1:0]  load_mode;
  logic [2:0]  ALUOp;
  logic        ex_stall;
  logic        out_valid;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  write_register;
  logic [31:0] branch_target;
  logic        zero;
  logic        branch_taken;
  logic        out_RegWrite;
  logic        out_MemWrite;
  logic        out_MemRead;
  logic        out_MemToReg;
  logic [1:0]  out_load_mode;

  modport master (
    output in_valid, instr_bits_15_11, instr_bits_20_16,
    output extended_bits, read_data1, read_data2, new_pc_value,
    output RegDst, RegWrite, ALUSrc, MemWrite, MemRead,
    output MemToReg, Branch, load_mode, ALUOp,
    input  ex_stall, out_valid, alu_result, store_data,
    input  write_register, branch_target, zero, branch_taken,
    input  out_RegWrite, out_MemWrite, out_MemRead,
    input  out_MemToReg, out_load_mode
  );

  modport slave (
    input  in_valid, instr_bits_15_11, instr_bits_20_16,
    input  extended_bits, read_data1, read_data2, new_pc_value,
    input  RegDst, RegWrite, ALUSrc, MemWrite, MemRead,
    input  MemToReg, Branch, load_mode, ALUOp,
    output ex_stall, out_valid, alu_result, store_data,
    output write_register, branch_target, zero, branch_taken,
    output out_RegWrite, out_MemWrite, out_MemRead,
    output out_MemToReg, out_load_mode
  );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: ALU, destination select, branch target, EX/MEM register.
// `define EX_MULDIV_EN adds the iterative multu/divu unit with HI/LO and mfhi/mflo.
module ex_stage #(
  parameter int MULDIV_CYCLES = 32
) (
  input logic   clk,
  input logic   reset,
  ex_stage_if.slave bus
);
  logic [31:0] op_b;
  logic [31:0] res;
  logic        wr_ok;
  logic        is_md;
  logic        v;
  logic [5:0]  funct;
  logic [4:0]  shamt;

  if (MULDIV_CYCLES != 32) begin : g_bad_cfg
    $error("ex_stage: MULDIV_CYCLES must be 32");
  end

  assign funct = bus.extended_bits[5:0];
  assign shamt = bus.extended_bits[10:6];

`ifdef EX_MULDIV_EN
  localparam int CW = $clog2(MULDIV_CYCLES);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          is_div;
  logic [31:0]   hi, lo;
  logic [31:0]   acc_hi, acc_lo;
  logic [31:0]   divisor;
  logic [32:0]   mul_sum;
  logic [32:0]   div_sh;
  logic          div_ge;
  logic [31:0]   div_rem;

  assign is_md = bus.in_valid && bus.ALUOp == 3'b010 &&
                 (funct == 6'h19 || funct == 6'h1B);
  assign bus.ex_stall = (state == S_IDLE && is_md) ||
                        state == S_BUSY;

  // acc_hi is the running partial product / remainder,
  // acc_lo the multiplier / quotient shift register.
  assign mul_sum = {1'b0, acc_hi} +
                   (acc_lo[0] ? {1'b0, divisor} : 33'd0);
  assign div_sh  = {acc_hi, acc_lo[31]};
  assign div_ge  = div_sh >= {1'b0, divisor};
  assign div_rem = div_sh[31:0] - divisor;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      is_div  <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      divisor <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (is_md) begin
          state   <= S_BUSY;
          cnt     <= '0;
          is_div  <= funct == 6'h1B;
          acc_hi  <= '0;
          acc_lo  <= bus.read_data1;
          divisor <= bus.read_data2;
        end
        S_BUSY: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(MULDIV_CYCLES - 1))
            state <= S_DONE;
          if (!is_div)
            {acc_hi, acc_lo} <= {mul_sum, acc_lo[31:1]};
          else if (div_ge)
            {acc_hi, acc_lo} <= {div_rem, acc_lo[30:0], 1'b1};
          else
            {acc_hi, acc_lo} <= {div_sh[31:0], acc_lo[30:0], 1'b0};
        end
        S_DONE: begin
          hi    <= acc_hi;
          lo    <= acc_lo;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`else
  assign is_md        = 1'b0;
  assign bus.ex_stall = 1'b0;
`endif

  always_comb begin
    op_b  = bus.ALUSrc ? bus.extended_bits : bus.read_data2;
    res   = '0;
    wr_ok = 1'b1;
    unique case (bus.ALUOp)
      3'b000: res = bus.read_data1 + op_b;
      3'b001: res = bus.read_data1 - op_b;
      3'b011: res = bus.read_data1 & op_b;
      3'b100: res = bus.read_data1 | op_b;
      3'b101: res = {31'd0, $signed(bus.read_data1) < $signed(op_b)};
      3'b010: begin
        unique case (funct)
          6'h20: res = bus.read_data1 + op_b;
          6'h22: res = bus.read_data1 - op_b;
          6'h24: res = bus.read_data1 & op_b;
          6'h25: res = bus.read_data1 | op_b;
          6'h2A: res = {31'd0, $signed(bus.read_data1) < $signed(op_b)};
          6'h00: res = bus.read_data2 << shamt;
          6'h02: res = bus.read_data2 >> shamt;
`ifdef EX_MULDIV_EN
          6'h10: res = hi;
          6'h12: res = lo;
          6'h19, 6'h1B: res = '0;
`endif
          default: wr_ok = 1'b0;
        endcase
      end
      default: res = '0;
    endcase
  end

  // muldiv writes no GPR, so every cycle it occupies EX is a bubble
  assign v = bus.in_valid & ~is_md;

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid      <= 1'b0;
      bus.alu_result     <= '0;
      bus.store_data     <= '0;
      bus.write_register <= '0;
      bus.branch_target  <= '0;
      bus.zero           <= 1'b0;
      bus.branch_taken   <= 1'b0;
      bus.out_RegWrite   <= 1'b0;
      bus.out_MemWrite   <= 1'b0;
      bus.out_MemRead    <= 1'b0;
      bus.out_MemToReg   <= 1'b0;
      bus.out_load_mode  <= '0;
    end else begin
      bus.out_valid      <= v;
      bus.alu_result     <= res;
      bus.store_data     <= bus.read_data2;
      bus.write_register <= bus.RegDst ? bus.instr_bits_15_11
                                       : bus.instr_bits_20_16;
      bus.branch_target  <= bus.new_pc_value + (bus.extended_bits << 2);
      bus.zero           <= res == '0;
      bus.branch_taken   <= v & bus.Branch & (res == '0);
      bus.out_RegWrite   <= v & bus.RegWrite & wr_ok;
      bus.out_MemWrite   <= v & bus.MemWrite;
      bus.out_MemRead    <= v & bus.MemRead;
      bus.out_MemToReg   <= v & bus.MemToReg;
      bus.out_load_mode  <= v ? bus.load_mode : 2'b00;
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases plus random
// instructions checked against a behavioural model of the stage.
module tb_ex_stage;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ex_stage_if bus();
  ex_stage #(.MULDIV_CYCLES(32)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  logic        e_valid, e_rw, e_mw, e_mr, e_m2r, e_zero, e_taken;
  logic [1:0]  e_lm;
  logic [4:0]  e_wreg;
  logic [31:0] e_res, e_sd, e_tgt;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] op,
                       input logic [31:0] ext, input logic [31:0] a,
                       input logic [31:0] b, input logic alusrc,
                       input logic rw, input logic br);
    bus.in_valid         = v;
    bus.ALUOp            = op;
    bus.extended_bits    = ext;
    bus.read_data1       = a;
    bus.read_data2       = b;
    bus.ALUSrc           = alusrc;
    bus.RegWrite         = rw;
    bus.Branch           = br;
    bus.RegDst           = 1'($urandom_range(0, 1));
    bus.instr_bits_15_11 = 5'($urandom);
    bus.instr_bits_20_16 = 5'($urandom);
    bus.new_pc_value     = $urandom & 32'hFFFF_FFFC;
    bus.MemWrite         = 1'($urandom_range(0, 1));
    bus.MemRead          = 1'($urandom_range(0, 1));
    bus.MemToReg         = 1'($urandom_range(0, 1));
    bus.load_mode        = 2'($urandom);
  endtask

  function automatic logic md_instr();
`ifdef EX_MULDIV_EN
    return bus.in_valid && bus.ALUOp == 3'b010 &&
           (bus.extended_bits[5:0] == 6'h19 ||
            bus.extended_bits[5:0] == 6'h1B);
`else
    return 1'b0;
`endif
  endfunction

  task automatic predict();
    logic [31:0] a, b;
    int sa, sb;
    logic ok;
    a  = bus.read_data1;
    b  = bus.ALUSrc ? bus.extended_bits : bus.read_data2;
    sa = a;
    sb = b;
    ok = 1'b1;
    e_res = 32'd0;
    case (bus.ALUOp)
      3'd0: e_res = a + b;
      3'd1: e_res = a - b;
      3'd3: e_res = a & b;
      3'd4: e_res = a | b;
      3'd5: e_res = (sa < sb) ? 32'd1 : 32'd0;
      3'd2: case (bus.extended_bits[5:0])
        6'h20: e_res = a + b;
        6'h22: e_res = a - b;
        6'h24: e_res = a & b;
        6'h25: e_res = a | b;
        6'h2A: e_res = (sa < sb) ? 32'd1 : 32'd0;
        6'h00: e_res = bus.read_data2 << bus.extended_bits[10:6];
        6'h02: e_res = bus.read_data2 >> bus.extended_bits[10:6];
`ifdef EX_MULDIV_EN
        6'h10: e_res = m_hi;
        6'h12: e_res = m_lo;
        6'h19, 6'h1B: e_res = 32'd0;
`endif
        default: ok = 1'b0;
      endcase
      default: e_res = 32'd0;
    endcase
    e_valid = bus.in_valid && !md_instr();
    e_rw    = e_valid && bus.RegWrite && ok;
    e_mw    = e_valid && bus.MemWrite;
    e_mr    = e_valid && bus.MemRead;
    e_m2r   = e_valid && bus.MemToReg;
    e_lm    = e_valid ? bus.load_mode : 2'b00;
    e_wreg  = bus.RegDst ? bus.instr_bits_15_11 : bus.instr_bits_20_16;
    e_sd    = bus.read_data2;
    e_tgt   = bus.new_pc_value + bus.extended_bits * 4;
    e_zero  = e_res == 32'd0;
    e_taken = e_valid && bus.Branch && e_zero;
  endtask

  task automatic check_out();
    chk("out_valid", 32'(bus.out_valid), 32'(e_valid));
    chk("out_RegWrite", 32'(bus.out_RegWrite), 32'(e_rw));
    chk("out_MemWrite", 32'(bus.out_MemWrite), 32'(e_mw));
    chk("out_MemRead", 32'(bus.out_MemRead), 32'(e_mr));
    chk("out_MemToReg", 32'(bus.out_MemToReg), 32'(e_m2r));
    chk("out_load_mode", 32'(bus.out_load_mode), 32'(e_lm));
    chk("branch_taken", 32'(bus.branch_taken), 32'(e_taken));
    if (e_valid) begin
      chk("alu_result", bus.alu_result, e_res);
      chk("write_register", 32'(bus.write_register), 32'(e_wreg));
      chk("store_data", bus.store_data, e_sd);
      chk("branch_target", bus.branch_target, e_tgt);
      chk("zero", 32'(bus.zero), 32'(e_zero));
    end
  endtask

  task automatic step();
    #1;
    chk("ex_stall_single", 32'(bus.ex_stall), 32'd0);
    predict();
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ex_stall"}, 32'(bus.ex_stall), 32'd0);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_alu_result"}, bus.alu_result, 32'd0);
    chk({tag, "_store_data"}, bus.store_data, 32'd0);
    chk({tag, "_write_register"}, 32'(bus.write_register), 32'd0);
    chk({tag, "_branch_target"}, bus.branch_target, 32'd0);
    chk({tag, "_zero"}, 32'(bus.zero), 32'd0);
    chk({tag, "_branch_taken"}, 32'(bus.branch_taken), 32'd0);
    chk({tag, "_ctrl"}, 32'({bus.out_RegWrite, bus.out_MemWrite,
                             bus.out_MemRead, bus.out_MemToReg}), 32'd0);
    chk({tag, "_load_mode"}, 32'(bus.out_load_mode), 32'd0);
  endtask

  task automatic rtype(input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b);
    drive(1'b1, 3'b010, {21'd0, 5'd0, f}, a, b, 1'b0, 1'b1, 1'b0);
    step();
  endtask

`ifdef EX_MULDIV_EN
  task automatic md_op(input logic [31:0] a, input logic [31:0] b,
                       input logic div);
    int n;
    logic [63:0] p;
    drive(1'b1, 3'b010, {26'd0, div ? 6'h1B : 6'h19}, a, b,
          1'b0, 1'b0, 1'b0);
    #1;
    chk("md_stall_start", 32'(bus.ex_stall), 32'd1);
    n = 0;
    while (bus.ex_stall === 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      chk("md_out_valid", 32'(bus.out_valid), 32'd0);
    end
    chk("md_stall_cycles", 32'(n), 32'd33);
    @(posedge clk);
    #1;
    chk("md_done_out_valid", 32'(bus.out_valid), 32'd0);
    if (div) begin
      m_lo = (b == 0) ? 32'hFFFF_FFFF : a / b;
      m_hi = (b == 0) ? a : a % b;
    end else begin
      p = 64'(a) * 64'(b);
      {m_hi, m_lo} = p;
    end
    bus.in_valid = 1'b0;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] fl [13];
    logic [2:0] op;
    logic [5:0] f;
    logic [31:0] a, b, ext;
    fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02,
           6'h10, 6'h12, 6'h19, 6'h1B, 6'h3F, 6'h07};

    reset = 1'b1;
    drive(1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    reset = 1'b0;

    drive(1'b1, 3'b010, 32'h20, 32'd7, 32'd5, 1'b0, 1'b1, 1'b0);
    bus.RegDst = 1'b1;
    bus.instr_bits_15_11 = 5'd9;
    step();
    chk("add_result", bus.alu_result, 32'd12);
    chk("add_wreg", 32'(bus.write_register), 32'd9);
    chk("add_regwrite", 32'(bus.out_RegWrite), 32'd1);

    drive(1'b1, 3'b001, 32'hFFFF_FFFE, 32'h1234, 32'h1234,
          1'b0, 1'b0, 1'b1);
    bus.new_pc_value = 32'h100;
    step();
    chk("beq_zero", 32'(bus.zero), 32'd1);
    chk("beq_taken", 32'(bus.branch_taken), 32'd1);
    chk("beq_target", bus.branch_target, 32'hF8);

    drive(1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    step();

`ifdef EX_MULDIV_EN
    md_op(32'hFFFF_FFFF, 32'd2, 1'b0);
    rtype(6'h10, 32'd0, 32'd0);
    chk("multu_hi", bus.alu_result, 32'd1);
    rtype(6'h12, 32'd0, 32'd0);
    chk("multu_lo", bus.alu_result, 32'hFFFF_FFFE);
    md_op(32'd100, 32'd0, 1'b1);
    rtype(6'h12, 32'd0, 32'd0);
    chk("div0_lo", bus.alu_result, 32'hFFFF_FFFF);
    rtype(6'h10, 32'd0, 32'd0);
    chk("div0_hi", bus.alu_result, 32'd100);
    md_op(32'd100, 32'd7, 1'b1);
    rtype(6'h12, 32'd0, 32'd0);
    chk("div7_lo", bus.alu_result, 32'd14);
    rtype(6'h10, 32'd0, 32'd0);
    chk("div7_hi", bus.alu_result, 32'd2);

    drive(1'b1, 3'b010, 32'h19, 32'd123, 32'd456, 1'b0, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    chk("abort_busy_stall", 32'(bus.ex_stall), 32'd1);
    reset = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk_zero("abort");
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    rtype(6'h20, 32'd40, 32'd2);
    chk("abort_add", bus.alu_result, 32'd42);
    rtype(6'h10, 32'd0, 32'd0);
    rtype(6'h12, 32'd0, 32'd0);
`else
    rtype(6'h19, 32'hFFFF_FFFF, 32'd2);
    chk("nomd_multu_regwrite", 32'(bus.out_RegWrite), 32'd0);
    rtype(6'h10, 32'd0, 32'd0);
    drive(1'b1, 3'b000, 32'd1, 32'd2, 32'd3, 1'b1, 1'b1, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_zero("mid_reset");
    reset = 1'b0;
`endif

    for (int i = 0; i < 80; i++) begin
      op = 3'($urandom_range(0, 7));
      f  = fl[$urandom_range(0, 12)];
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 5) == 0) b = a;
      ext = {21'($urandom), 5'($urandom), f};
`ifdef EX_MULDIV_EN
      if (op == 3'b010 && (f == 6'h19 || f == 6'h1B)) begin
        if ($urandom_range(0, 3) == 0) b = 32'd0;
        md_op(a, b, f == 6'h1B);
        continue;
      end
`endif
      drive(1'($urandom_range(0, 7) != 0), op, ext, a, b,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
